dmem_store_buffer: RTL

//  Posted-write store buffer between the pipeline's MEM-stage DMEM port and the data memory.

---
 rtl/dmem_sb_pkg.sv | 18 +
 rtl/sb_fwd_match.sv | 33 +++
 rtl/dmem_store_buffer.sv | 109 ++++++++++
 3 files changed

// File: rtl/dmem_sb_pkg.sv
// Shared widths, word-address slicing and entry type for the DMEM store buffer.
package dmem_sb_pkg;

  localparam int unsigned SbAddrW = 32;
  localparam int unsigned SbDataW = 32;
  localparam int unsigned WordLsb = 2;

  typedef struct packed {
    logic               valid;
    logic [SbAddrW-1:0] waddr;
    logic [SbDataW-1:0] wdata;
  } sb_entry_t;

  function automatic logic word_match(input logic [SbAddrW-1:0] a, input logic [SbAddrW-1:0] b);
    return a[SbAddrW-1:WordLsb] == b[SbAddrW-1:WordLsb];
  endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-first priority match of a load address against the live store-buffer entries.
module sb_fwd_match
  import dmem_sb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  sb_entry_t [DEPTH-1:0] entries,
  input  logic [PtrW-1:0]       tail,
  input  logic [CntW-1:0]       count,
  input  logic [SbAddrW-1:0]    addr,
  output logic                  hit,
  output logic [SbDataW-1:0]    data
);

  logic [PtrW-1:0] idx;

  // Walk oldest to youngest so the last hit (the youngest) wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = tail - count[PtrW-1:0] + PtrW'(k);
      if (CntW'(k) < count && entries[idx].valid && word_match(entries[idx].waddr, addr)) begin
        hit  = 1'b1;
        data = entries[idx].wdata;
      end
    end
  end

endmodule

// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer with load forwarding between the MEM stage and data memory.
// Optional STORE_MERGE_EN: a store to the youngest non-head entry's word overwrites it.
module dmem_store_buffer
  import dmem_sb_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = SbAddrW,
  parameter int unsigned DATA_W = SbDataW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wvalid,
  input  logic              mem_wready,
  output logic              sb_empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  sb_entry_t [DEPTH-1:0] ents_q, ents_d;
  logic [PtrW-1:0]       head_q, head_d, tail_q, tail_d, young_idx;
  logic [CntW-1:0]       count_q, count_d;
  logic                  full, pop, push, merge, fwd_hit;
  logic [DATA_W-1:0]     fwd_data;

  assign full      = (count_q == CntW'(DEPTH));
  assign sb_empty  = (count_q == '0);
  assign young_idx = tail_q - PtrW'(1);

  assign mem_wvalid = !sb_empty;
  assign mem_waddr  = ents_q[head_q].waddr;
  assign mem_wdata  = ents_q[head_q].wdata;
  assign pop        = mem_wvalid && mem_wready;

`ifdef STORE_MERGE_EN
  // The head may already be on the bus, so only a younger entry can absorb the store.
  assign merge = cpu_we && (count_q >= CntW'(2)) && ents_q[young_idx].valid &&
                 word_match(ents_q[young_idx].waddr, cpu_addr);
`else
  assign merge = 1'b0;
`endif

  assign push      = cpu_we && !merge && (!full || pop);
  assign cpu_stall = cpu_we && full && !pop && !merge;

  always_comb begin
    ents_d  = ents_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      ents_d[head_q].valid = 1'b0;
      head_d               = head_q + PtrW'(1);
    end
    // When full, tail == head: the push must land after the pop clears the slot.
    if (push) begin
      ents_d[tail_q].valid = 1'b1;
      ents_d[tail_q].waddr = cpu_addr;
      ents_d[tail_q].wdata = cpu_wdata;
      tail_d               = tail_q + PtrW'(1);
    end
    if (merge) begin
      ents_d[young_idx].wdata = cpu_wdata;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ents_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      ents_q  <= ents_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  sb_fwd_match #(
    .DEPTH (DEPTH)
  ) u_fwd_match (
    .entries (ents_q),
    .tail    (tail_q),
    .count   (count_q),
    .addr    (cpu_addr),
    .hit     (fwd_hit),
    .data    (fwd_data)
  );

  assign mem_raddr = cpu_addr;
  assign cpu_rdata = fwd_hit ? fwd_data : mem_rdata;

endmodule
